// File: rtl/interrupt_ctrl.sv
// Interrupt and reset sequencer in front of the CPU datapath.
// Synchronizes the NMI/IRQ pins, latches NMI falling edges, arbitrates
// reset > NMI > BRK > IRQ at instruction boundaries, and supplies the two
// vector address bytes to the datapath constant bus.
//
// Handshake: int_take is a level request that stays high until the
// sequencer answers with a one-cycle int_ack. After that, vec_valid
// qualifies vec_const, and each vec_step pulse consumes one vector byte
// (low, then high). Strobes seen in a state that does not use them are
// ignored.
module interrupt_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,  // must be at least 2
   parameter logic [7:0]  NMI_VEC     = 8'hFA,
   parameter logic [7:0]  RST_VEC     = 8'hFC,
   parameter logic [7:0]  IRQ_VEC     = 8'hFE
) (
   input  logic       ph2,
   input  logic       reset,
   input  logic       nmi_b,
   input  logic       irq_b,
   input  logic       i_flag,
   input  logic       instr_boundary,
   input  logic       brk_req,
   input  logic       int_ack,
   input  logic       vec_step,
   output logic       int_take,
   output logic [1:0] int_kind,
   output logic       b_flag,
   output logic [7:0] vec_const,
   output logic       vec_valid,
   // FSM state for observation: 0 IDLE, 1 TAKE, 2 VEC_LO, 3 VEC_HI
   output logic [1:0] debug_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TAKE   = 2'd1,
      VEC_LO = 2'd2,
      VEC_HI = 2'd3
   } state_t;

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_IRQ  = 2'b01;
   localparam logic [1:0] KIND_NMI  = 2'b10;
   localparam logic [1:0] KIND_RST  = 2'b11;

   state_t                 state;
   logic [SYNC_STAGES-1:0] nmi_sync;
   logic [SYNC_STAGES-1:0] irq_sync;
   logic                   nmi_s;
   logic                   irq_s;
   logic                   prev_nmi;
   logic                   nmi_fall;
   logic                   irq_req;
   logic                   nmi_latched;
   logic                   rst_pending;
   logic [7:0]             vec_base;

   assign nmi_s       = nmi_sync[SYNC_STAGES-1];
   assign irq_s       = irq_sync[SYNC_STAGES-1];
   // A fall is only seen once per low period: prev_nmi must be high again first.
   assign nmi_fall    = prev_nmi & ~nmi_s;
   // IRQ is a level request; it is not held anywhere, only sampled at the boundary.
   assign irq_req     = ~irq_s & ~i_flag;
   assign debug_state = state;

   // Pin synchronizers and the NMI edge-detect history; idle level is high.
   always_ff @(posedge ph2) begin
      if (reset) begin
         nmi_sync <= '1;
         irq_sync <= '1;
         prev_nmi <= 1'b1;
      end else begin
         nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_b};
         irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_b};
         prev_nmi <= nmi_s;
      end
   end

   // Request capture, sequencing FSM and registered outputs.
   always_ff @(posedge ph2) begin
      if (reset) begin
         state       <= IDLE;
         rst_pending <= 1'b1;
         nmi_latched <= 1'b0;
         int_take    <= 1'b0;
         int_kind    <= KIND_NONE;
         b_flag      <= 1'b0;
         vec_const   <= 8'h00;
         vec_valid   <= 1'b0;
         vec_base    <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (rst_pending) begin
                  // Reset vector goes out without waiting for a boundary.
                  state    <= TAKE;
                  int_take <= 1'b1;
                  int_kind <= KIND_RST;
                  b_flag   <= 1'b0;
                  vec_base <= RST_VEC;
               end else if (instr_boundary) begin
                  if (nmi_latched) begin
                     state    <= TAKE;
                     int_take <= 1'b1;
                     int_kind <= KIND_NMI;
                     b_flag   <= 1'b0;
                     vec_base <= NMI_VEC;
                  end else if (brk_req) begin
                     state    <= TAKE;
                     int_take <= 1'b1;
                     int_kind <= KIND_IRQ;
                     b_flag   <= 1'b1;
                     vec_base <= IRQ_VEC;
                  end else if (irq_req) begin
                     state    <= TAKE;
                     int_take <= 1'b1;
                     int_kind <= KIND_IRQ;
                     b_flag   <= 1'b0;
                     vec_base <= IRQ_VEC;
                  end
               end
            end
            TAKE: begin
               if (int_ack) begin
                  state     <= VEC_LO;
                  int_take  <= 1'b0;
                  vec_valid <= 1'b1;
                  vec_const <= vec_base;
                  if (int_kind == KIND_RST) rst_pending <= 1'b0;
                  if (int_kind == KIND_NMI) nmi_latched <= 1'b0;
               end
            end
            VEC_LO: begin
               if (vec_step) begin
                  state     <= VEC_HI;
                  vec_const <= vec_base + 8'd1;
               end
            end
            VEC_HI: begin
               if (vec_step) begin
                  state     <= IDLE;
                  vec_valid <= 1'b0;
                  vec_const <= 8'h00;
                  int_kind  <= KIND_NONE;
                  b_flag    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         // Placed last so a new NMI edge overrides the clear on the ack edge.
         if (nmi_fall) nmi_latched <= 1'b1;
      end
   end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios plus a
// randomized request/handshake loop checked against a priority model.
module tb_interrupt_ctrl;

   logic       ph2 = 1'b0;
   logic       reset = 1'b1;
   logic       nmi_b = 1'b1;
   logic       irq_b = 1'b1;
   logic       i_flag = 1'b0;
   logic       instr_boundary = 1'b0;
   logic       brk_req = 1'b0;
   logic       int_ack = 1'b0;
   logic       vec_step = 1'b0;
   logic       int_take;
   logic [1:0] int_kind;
   logic       b_flag;
   logic [7:0] vec_const;
   logic       vec_valid;
   logic [1:0] debug_state;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];   // {kind, b_flag, vector base}
   bit nmi_pend = 1'b0;

   interrupt_ctrl dut (
      .ph2(ph2), .reset(reset), .nmi_b(nmi_b), .irq_b(irq_b), .i_flag(i_flag),
      .instr_boundary(instr_boundary), .brk_req(brk_req), .int_ack(int_ack),
      .vec_step(vec_step), .int_take(int_take), .int_kind(int_kind),
      .b_flag(b_flag), .vec_const(vec_const), .vec_valid(vec_valid),
      .debug_state(debug_state)
   );

   // clock and watchdog
   always #5 ph2 = ~ph2;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge ph2);
      #1;
   endtask

   task automatic pulse_boundary();
      instr_boundary = 1'b1;
      tick();
      instr_boundary = 1'b0;
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic pulse_step();
      vec_step = 1'b1;
      tick();
      vec_step = 1'b0;
   endtask

   // reference model: which request wins at a boundary -> {any, kind, b, base}
   function automatic logic [11:0] ref_capture(input bit nmi, input bit brk,
                                               input bit irq_low, input bit iflg);
      if (nmi) return {1'b1, 2'b10, 1'b0, 8'hFA};
      if (brk) return {1'b1, 2'b01, 1'b1, 8'hFE};
      if (irq_low && !iflg) return {1'b1, 2'b01, 1'b0, 8'hFE};
      return 12'h000;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (int_take !== 1'b0) begin errors++; $display("FAIL rst_take: got %b exp 0", int_take); end
      checks++; if (int_kind !== 2'b00) begin errors++; $display("FAIL rst_kind: got %b exp 00", int_kind); end
      checks++; if (b_flag !== 1'b0) begin errors++; $display("FAIL rst_bflag: got %b exp 0", b_flag); end
      checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL rst_vvalid: got %b exp 0", vec_valid); end
      checks++; if (vec_const !== 8'h00) begin errors++; $display("FAIL rst_vconst: got %h exp 00", vec_const); end
      checks++; if (debug_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", debug_state); end
      reset = 1'b0;
      tick();
      checks++; if (int_take !== 1'b1 || int_kind !== 2'b11) begin errors++; $display("FAIL rst_request: got take=%b kind=%b exp take=1 kind=11", int_take, int_kind); end
      checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL rst_take_vvalid: got %b exp 0", vec_valid); end
      pulse_ack();
      checks++; if (vec_valid !== 1'b1 || vec_const !== 8'hFC || int_take !== 1'b0) begin errors++; $display("FAIL rst_vec_lo: got valid=%b const=%h take=%b exp 1 FC 0", vec_valid, vec_const, int_take); end
      pulse_step();
      checks++; if (vec_valid !== 1'b1 || vec_const !== 8'hFD) begin errors++; $display("FAIL rst_vec_hi: got valid=%b const=%h exp 1 FD", vec_valid, vec_const); end
      pulse_step();
      checks++; if (vec_valid !== 1'b0 || int_kind !== 2'b00) begin errors++; $display("FAIL rst_done: got valid=%b kind=%b exp 0 00", vec_valid, int_kind); end
      tick();
      checks++; if (int_take !== 1'b0) begin errors++; $display("FAIL rst_once: got %b exp 0", int_take); end
   endtask

   task automatic test_nmi();
      nmi_b = 1'b0;
      tick();
      tick();
      pulse_boundary();  // nmi_latched is only set on this edge, too late
      checks++; if (int_take !== 1'b0) begin errors++; $display("FAIL nmi_early: got %b exp 0", int_take); end
      pulse_boundary();
      checks++; if (int_take !== 1'b1 || int_kind !== 2'b10 || b_flag !== 1'b0) begin errors++; $display("FAIL nmi_take: got take=%b kind=%b b=%b exp 1 10 0", int_take, int_kind, b_flag); end
      pulse_ack();
      checks++; if (vec_const !== 8'hFA || vec_valid !== 1'b1) begin errors++; $display("FAIL nmi_vec_lo: got %h valid=%b exp FA 1", vec_const, vec_valid); end
      pulse_step();
      checks++; if (vec_const !== 8'hFB) begin errors++; $display("FAIL nmi_vec_hi: got %h exp FB", vec_const); end
      pulse_step();
      pulse_boundary();  // pin still low: no new edge
      checks++; if (int_take !== 1'b0) begin errors++; $display("FAIL nmi_held: got %b exp 0", int_take); end
      nmi_b = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_irq_mask();
      irq_b = 1'b0;
      i_flag = 1'b1;
      repeat (3) tick();
      pulse_boundary();
      checks++; if (int_take !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b exp 0", int_take); end
      i_flag = 1'b0;
      pulse_boundary();
      checks++; if (int_take !== 1'b1 || int_kind !== 2'b01 || b_flag !== 1'b0) begin errors++; $display("FAIL irq_take: got take=%b kind=%b b=%b exp 1 01 0", int_take, int_kind, b_flag); end
      irq_b = 1'b1;
      i_flag = 1'b1;
      pulse_step();  // ignored in TAKE
      checks++; if (int_take !== 1'b1 || vec_valid !== 1'b0 || int_kind !== 2'b01) begin errors++; $display("FAIL irq_hold: got take=%b valid=%b kind=%b exp 1 0 01", int_take, vec_valid, int_kind); end
      pulse_ack();
      checks++; if (vec_const !== 8'hFE || int_kind !== 2'b01) begin errors++; $display("FAIL irq_vec_lo: got %h kind=%b exp FE 01", vec_const, int_kind); end
      pulse_step();
      checks++; if (vec_const !== 8'hFF) begin errors++; $display("FAIL irq_vec_hi: got %h exp FF", vec_const); end
      pulse_step();
      checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL irq_done: got %b exp 0", vec_valid); end
      i_flag = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_priority();
      irq_b = 1'b0;
      repeat (3) tick();
      brk_req = 1'b1;
      pulse_boundary();
      brk_req = 1'b0;
      checks++; if (int_kind !== 2'b01 || b_flag !== 1'b1) begin errors++; $display("FAIL brk_over_irq: got kind=%b b=%b exp 01 1", int_kind, b_flag); end
      pulse_ack();
      checks++; if (vec_const !== 8'hFE) begin errors++; $display("FAIL brk_vec: got %h exp FE", vec_const); end
      pulse_step();
      pulse_step();
      checks++; if (b_flag !== 1'b0) begin errors++; $display("FAIL brk_bclear: got %b exp 0", b_flag); end
      nmi_b = 1'b0;
      repeat (3) tick();
      nmi_b = 1'b1;
      brk_req = 1'b1;
      pulse_boundary();
      brk_req = 1'b0;
      checks++; if (int_kind !== 2'b10 || b_flag !== 1'b0) begin errors++; $display("FAIL nmi_over_brk: got kind=%b b=%b exp 10 0", int_kind, b_flag); end
      pulse_ack();
      checks++; if (vec_const !== 8'hFA) begin errors++; $display("FAIL nmi_over_brk_vec: got %h exp FA", vec_const); end
      pulse_step();
      pulse_step();
      irq_b = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_nmi_during_seq();
      irq_b = 1'b0;
      repeat (3) tick();
      pulse_boundary();
      pulse_ack();
      nmi_b = 1'b0;
      repeat (3) tick();
      checks++; if (vec_const !== 8'hFE || debug_state !== 2'd2) begin errors++; $display("FAIL seq_nmi_lo: got %h state=%0d exp FE 2", vec_const, debug_state); end
      nmi_b = 1'b1;
      irq_b = 1'b1;
      pulse_step();
      checks++; if (vec_const !== 8'hFF) begin errors++; $display("FAIL seq_nmi_hi: got %h exp FF", vec_const); end
      pulse_step();
      checks++; if (int_kind !== 2'b00 || int_take !== 1'b0) begin errors++; $display("FAIL seq_nmi_idle: got kind=%b take=%b exp 00 0", int_kind, int_take); end
      repeat (2) tick();
      pulse_boundary();
      checks++; if (int_take !== 1'b1 || int_kind !== 2'b10) begin errors++; $display("FAIL seq_nmi_served: got take=%b kind=%b exp 1 10", int_take, int_kind); end
      pulse_ack();
      pulse_step();
      pulse_step();
   endtask

   task automatic test_set_wins();
      nmi_b = 1'b0;
      repeat (3) tick();
      nmi_b = 1'b1;
      repeat (3) tick();
      pulse_boundary();
      checks++; if (int_kind !== 2'b10) begin errors++; $display("FAIL setwin_take: got %b exp 10", int_kind); end
      nmi_b = 1'b0;
      tick();
      tick();
      pulse_ack();  // this edge both clears and re-sets the latch
      checks++; if (vec_const !== 8'hFA) begin errors++; $display("FAIL setwin_vec: got %h exp FA", vec_const); end
      nmi_b = 1'b1;
      pulse_step();
      pulse_step();
      repeat (2) tick();
      pulse_boundary();
      checks++; if (int_take !== 1'b1 || int_kind !== 2'b10) begin errors++; $display("FAIL nmi_set_wins: got take=%b kind=%b exp 1 10", int_take, int_kind); end
      pulse_ack();
      pulse_step();
      pulse_step();
   endtask

   task automatic test_reset_mid();
      irq_b = 1'b0;
      repeat (3) tick();
      pulse_boundary();
      pulse_ack();
      pulse_step();
      checks++; if (vec_const !== 8'hFF || debug_state !== 2'd3) begin errors++; $display("FAIL mid_pre: got %h state=%0d exp FF 3", vec_const, debug_state); end
      reset = 1'b1;
      tick();
      checks++; if (vec_valid !== 1'b0 || int_take !== 1'b0 || int_kind !== 2'b00) begin errors++; $display("FAIL mid_reset: got valid=%b take=%b kind=%b exp 0 0 00", vec_valid, int_take, int_kind); end
      irq_b = 1'b1;
      reset = 1'b0;
      tick();
      checks++; if (int_take !== 1'b1 || int_kind !== 2'b11) begin errors++; $display("FAIL mid_rst_req: got take=%b kind=%b exp 1 11", int_take, int_kind); end
      pulse_ack();
      checks++; if (vec_const !== 8'hFC) begin errors++; $display("FAIL mid_rst_vec: got %h exp FC", vec_const); end
      pulse_step();
      pulse_step();
      repeat (2) tick();
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         logic [11:0] exp;
         logic [10:0] e;
         bit brk;
         if ($urandom_range(0, 3) == 0) begin
            nmi_b = 1'b0;
            repeat (3) tick();
            nmi_b = 1'b1;
            repeat (2) tick();
            nmi_pend = 1'b1;
         end
         irq_b = 1'($urandom_range(0, 1));
         i_flag = 1'($urandom_range(0, 1));
         brk = ($urandom_range(0, 2) == 0);
         repeat ($urandom_range(2, 4)) tick();
         exp = ref_capture(nmi_pend, brk, !irq_b, i_flag);
         brk_req = brk;
         pulse_boundary();
         brk_req = 1'b0;
         if (!exp[11]) begin
            checks++; if (int_take !== 1'b0) begin errors++; $display("FAIL rnd_none it=%0d: got take=%b exp 0", it, int_take); end
         end else begin
            exp_q.push_back(exp[10:0]);
            if (exp[10:9] == 2'b10) nmi_pend = 1'b0;
            checks++; if (int_take !== 1'b1) begin errors++; $display("FAIL rnd_take it=%0d: got %b exp 1", it, int_take); end
            e = exp_q.pop_front();
            checks++; if (int_kind !== e[10:9] || b_flag !== e[8]) begin errors++; $display("FAIL rnd_kind it=%0d: got kind=%b b=%b exp %b %b", it, int_kind, b_flag, e[10:9], e[8]); end
            repeat ($urandom_range(0, 2)) begin
               irq_b = 1'($urandom_range(0, 1));
               i_flag = 1'($urandom_range(0, 1));
               vec_step = 1'($urandom_range(0, 1));
               instr_boundary = 1'($urandom_range(0, 1));
               tick();
               vec_step = 1'b0;
               instr_boundary = 1'b0;
               checks++; if (int_take !== 1'b1 || vec_valid !== 1'b0 || int_kind !== e[10:9]) begin errors++; $display("FAIL rnd_wait_take it=%0d: got take=%b valid=%b kind=%b exp 1 0 %b", it, int_take, vec_valid, int_kind, e[10:9]); end
            end
            pulse_ack();
            checks++; if (vec_valid !== 1'b1 || int_take !== 1'b0 || vec_const !== e[7:0]) begin errors++; $display("FAIL rnd_lo it=%0d: got valid=%b take=%b const=%h exp 1 0 %h", it, vec_valid, int_take, vec_const, e[7:0]); end
            repeat ($urandom_range(0, 2)) begin
               int_ack = 1'($urandom_range(0, 1));
               instr_boundary = 1'($urandom_range(0, 1));
               tick();
               int_ack = 1'b0;
               instr_boundary = 1'b0;
               checks++; if (vec_valid !== 1'b1 || vec_const !== e[7:0]) begin errors++; $display("FAIL rnd_lo_hold it=%0d: got valid=%b const=%h exp 1 %h", it, vec_valid, vec_const, e[7:0]); end
            end
            pulse_step();
            checks++; if (vec_valid !== 1'b1 || vec_const !== e[7:0] + 8'd1) begin errors++; $display("FAIL rnd_hi it=%0d: got valid=%b const=%h exp 1 %h", it, vec_valid, vec_const, e[7:0] + 8'd1); end
            repeat ($urandom_range(0, 2)) begin
               int_ack = 1'($urandom_range(0, 1));
               tick();
               int_ack = 1'b0;
               checks++; if (vec_const !== e[7:0] + 8'd1 || int_take !== 1'b0) begin errors++; $display("FAIL rnd_hi_hold it=%0d: got const=%h take=%b exp %h 0", it, vec_const, int_take, e[7:0] + 8'd1); end
            end
            pulse_step();
            checks++; if (vec_valid !== 1'b0 || int_kind !== 2'b00 || b_flag !== 1'b0 || int_take !== 1'b0) begin errors++; $display("FAIL rnd_end it=%0d: got valid=%b kind=%b b=%b take=%b exp 0 00 0 0", it, vec_valid, int_kind, b_flag, int_take); end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_queue: got %0d left exp 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_nmi();
      test_irq_mask();
      test_priority();
      test_nmi_during_seq();
      test_set_wins();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
Interrupt and reset sequencer that sits directly upstream of the CPU datapath.
- Synchronizes the external NMI and IRQ pins.
- Latches NMI falling edges, applies the I-flag mask to IRQ, and prioritizes reset, NMI, IRQ and BRK at instruction boundaries.
- Handshakes with the microcode sequencer and drives the vector-address constant byte onto the datapath `constant` input during the two vector-fetch steps.

Parameters:
- SYNC_STAGES, 2: flops in each pin synchronizer (minimum 2).
- NMI_VEC, 8'hFA: low byte of the NMI vector address.
- RST_VEC, 8'hFC: low byte of the reset vector address.
- IRQ_VEC, 8'hFE: low byte of the IRQ/BRK vector address.

Ports:
- ph2  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- nmi_b  in  1  external NMI, active low, asynchronous.
- irq_b  in  1  external IRQ, active low, level, asynchronous.
- i_flag  in  1  interrupt-disable flag (datapath p_s1[2]).
- instr_boundary  in  1  one-cycle pulse from the sequencer at the opcode-fetch decision point.
- brk_req  in  1  BRK opcode decoded; valid only with instr_boundary.
- int_ack  in  1  sequencer has begun the interrupt push sequence.
- vec_step  in  1  sequencer consumes the current vector byte.
- int_take  out  1  interrupt sequence requested; level, held until int_ack.
- int_kind  out  2  captured kind: 00 none, 01 IRQ/BRK, 10 NMI, 11 reset.
- b_flag  out  1  value of the B bit for the pushed P: 1 for BRK, 0 otherwise.
- vec_const  out  8  vector address byte for the datapath constant bus.
- vec_valid  out  1  vec_const is meaningful; the sequencer gates constant_en with it.

Behaviour:
Reset values (all outputs and state):
- State IDLE, rst_pending=1, nmi_latched=0, synchronizer flops=1 (inactive), prev-NMI flop=1.
- int_take=0, int_kind=00, b_flag=0, vec_const=8'h00, vec_valid=0.

Synchronizers and request sources:
- Each pin passes through a SYNC_STAGES flop chain; the sync outputs are nmi_s and irq_s.
- NMI edge: nmi_fall = prev_nmi & ~nmi_s. A set takes effect at the edge after the fall. nmi_b sampled low at edge k gives nmi_latched=1 after edge k+SYNC_STAGES.
- NMI held low does not re-trigger; a new edge requires nmi_s to return high for at least one cycle.
- irq_req = ~irq_s & ~i_flag, evaluated combinationally at the boundary. IRQ is not latched.

Priority at capture: reset > NMI > BRK > IRQ. BRK and IRQ share IRQ_VEC; b_flag distinguishes them.

FSM states: IDLE, TAKE, VEC_LO, VEC_HI.
- IDLE
  - rst_pending=1: go to TAKE with kind=11 next cycle, without waiting for instr_boundary.
  - Otherwise, on instr_boundary with any of nmi_latched, brk_req, irq_req: capture kind and b_flag, go to TAKE.
  - No request at the boundary: remain in IDLE.
- TAKE
  - int_take=1, int_kind stable.
  - On int_ack: go to VEC_LO and clear the captured source (nmi_latched or rst_pending). The clear happens on the same edge as the transition.
  - An NMI edge arriving on that same edge still sets nmi_latched; set wins over clear.
- VEC_LO
  - vec_valid=1, vec_const = selected base (NMI_VEC, RST_VEC or IRQ_VEC).
  - On vec_step: go to VEC_HI.
- VEC_HI
  - vec_valid=1, vec_const = base+1. The increment is 8-bit; wrap is impossible with legal vectors.
  - On vec_step: go to IDLE, int_kind=00, vec_valid=0, b_flag=0.

Boundary conditions:
- IRQ deasserts, or i_flag rises, while in TAKE: the captured kind is kept and the sequence completes.
- NMI edge during any non-IDLE state: latched and served at the next boundary after return to IDLE.
- instr_boundary, int_ack or vec_step asserted in a state that does not use it: ignored.
- reset asserted mid-sequence: everything returns to reset values on that edge. The reset vector is requested on the first cycle after reset deasserts.
- int_take is never asserted in the same cycle as vec_valid.

Test Plan:
- Reset release with no boundary pulse → int_take=1, kind=11 one cycle after reset deasserts. int_ack then two vec_step pulses → vec_const FC then FD, then IDLE.
- nmi_b low at edge k, boundary pulse at k+4 → int_take at k+5, kind=10, vectors FA/FB. With nmi_b held low, the next boundary raises no request.
- irq_b low with i_flag=1 at boundary → no int_take. Clear i_flag, next boundary → kind=01, b_flag=0, vectors FE/FF.
- brk_req and irq_req both present at the same boundary → kind=01, b_flag=1. The same boundary with nmi_latched also set → kind=10, b_flag=0.
- NMI edge arrives while in VEC_LO for an IRQ → the IRQ completes FE/FF, and the next boundary yields kind=10.
- reset pulse while in VEC_HI → vec_valid=0 immediately, then int_take with kind=11 after reset release.
